cci_test_ctrl: RTL
==================

CCI_TEST_CTRL -- requirements
Module: cci_test_ctrl

Interface
REQ-001 Parameter NUM_TEST_CSRS, default 8: number of test CSR slots; SHALL be >= 5.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 csr_wr_en  input  NUM_TEST_CSRS  one-hot per-slot write strobe, 1 cycle per write.
REQ-005 csr_wr_data  input  64  write data, shared across all slots; valid with any csr_wr_en bit.
REQ-006 csr_rd_data  output  64*NUM_TEST_CSRS  read value per slot; slot i at bits [64i +: 64].
REQ-007 engine_req_issued  input  1  engine issued one request this cycle.
REQ-008 engine_rsp_rcvd  input  1  engine received one response this cycle.
REQ-009 test_start  output  1  single-cycle pulse on each test launch.
REQ-010 test_enable  output  1  level; engine may issue requests only while high.
REQ-011 test_base_addr  output  64  latched buffer base address.
REQ-012 test_done  output  1  level; high in DONE only.

Function
REQ-013 Write slots SHALL be: 0 CTRL (bit0 start, bit1 stop, bit2 clear); 1 BASE_ADDR[63:0]; 2 ITER_LIMIT[31:0] (0 = unbounded); 3 TIMEOUT[31:0] cycles (0 = disabled); writes to other slots ignored.
REQ-014 BASE_ADDR, ITER_LIMIT and TIMEOUT SHALL be written only in IDLE or DONE; writes in RUN/DRAIN ignored.
REQ-015 Read slots SHALL be: 0 STATUS {59'0, error[4], timeout[3], done[2], state[1:0]}; 1 active cycle count; 2 issued count; 3 received count; 4 outstanding = issued - received (64-bit wrap); others 0.
REQ-016 csr_rd_data SHALL be registered: value reflects state/counters as of the previous cycle.
REQ-017 FSM states SHALL be IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-018 IDLE or DONE + CTRL write with start=1, stop=0: -> RUN next edge; issued, received, cycle counters, timeout and error flags cleared on that edge; test_start pulses in the first RUN cycle.
REQ-019 CTRL write with start=1 and stop=1 SHALL be treated as stop only; start bit in RUN/DRAIN ignored.
REQ-020 RUN: issued increments on engine_req_issued; when issued+1 == ITER_LIMIT (limit nonzero) -> DRAIN on the same edge as the increment.
REQ-021 RUN + CTRL stop -> DRAIN; RUN + cycle count reaching TIMEOUT (nonzero) -> DRAIN with timeout flag set; limit reached same cycle as stop/timeout -> DRAIN, timeout flag set only if timeout fired.
REQ-022 test_enable SHALL be registered, high exactly while state == RUN; engine_req_issued outside RUN ignored.
REQ-023 Received count SHALL increment on engine_rsp_rcvd in RUN, DRAIN or DONE; ignored in IDLE.
REQ-024 DRAIN -> DONE when issued == received, evaluated including the response arriving that cycle.
REQ-025 A response that would make received exceed issued SHALL set the sticky error flag; count still increments.
REQ-026 Cycle counter SHALL increment every cycle in RUN and DRAIN, hold otherwise.
REQ-027 CTRL clear in DONE -> IDLE, counters held; clear in other states ignored; clear with start in DONE: start wins.
REQ-028 All counters 64 bits, wrap silently; timeout compare on low 32 bits of cycle count.
REQ-029 test_base_addr SHALL drive the BASE_ADDR register directly.

Reset
REQ-030 On reset: state IDLE; all counters, flags, config registers, test_start, test_enable, test_done, test_base_addr and csr_rd_data 0.
REQ-031 Reset asserted in any state SHALL abort immediately; test_enable low the cycle after reset is sampled.

Verification
REQ-032 LIMIT=4, start, engine issues 4 then 4 responses -> test_start one pulse, test_enable high exactly 4 issue cycles, DONE, slot2=4, slot3=4, slot4=0.
REQ-033 LIMIT=0, TIMEOUT=100, start, continuous issue, no responses -> DRAIN after 100 RUN cycles, STATUS timeout=1, stays DRAIN until responses match.
REQ-034 Start+stop in same CTRL write from IDLE -> remains IDLE, no test_start pulse.
REQ-035 Response in IDLE and extra response in DONE -> IDLE count unchanged; DONE extra sets error bit, slot4 = 0xFFFF_FFFF_FFFF_FFFF.
REQ-036 Reset asserted mid-RUN with issued=7 -> next cycle all outputs 0, STATUS reads 0 one cycle later.
REQ-037 BASE_ADDR write during RUN -> ignored; write in DONE -> test_base_addr updates next edge.

Source files
------------

// File: rtl/cci_test_ctrl.sv
// Test controller for a CCI traffic engine: CSR-programmed launch, request/response accounting, drain-to-done.
// Latency: control outputs are registered and follow a CSR write by one edge; csr_rd_data lags internal state by one cycle.
// Backpressure: none; the engine may issue only while test_enable is high, and responses are counted whenever not IDLE.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   csr_wr_en/csr_wr_data one-hot slot write strobe with shared 64-bit data
//                         (0 CTRL {clear,stop,start}, 1 BASE_ADDR, 2 ITER_LIMIT, 3 TIMEOUT)
//   csr_rd_data           registered read slots (0 STATUS, 1 cycles, 2 issued, 3 received, 4 outstanding)
//   engine_req_issued/engine_rsp_rcvd  one event per cycle from the traffic engine
//   test_start            one-cycle pulse on the first RUN cycle
//   test_enable           high exactly while in RUN
//   test_base_addr        programmed buffer base address
//   test_done             high exactly while in DONE
// NUM_TEST_CSRS must be at least 5 so the read slots fit.
module cci_test_ctrl #(
    parameter int NUM_TEST_CSRS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_TEST_CSRS-1:0]      csr_wr_en,
    input  logic [63:0]                   csr_wr_data,
    output logic [64*NUM_TEST_CSRS-1:0]   csr_rd_data,
    input  logic                          engine_req_issued,
    input  logic                          engine_rsp_rcvd,
    output logic                          test_start,
    output logic                          test_enable,
    output logic [63:0]                   test_base_addr,
    output logic                          test_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] base_addr;
    logic [31:0] iter_limit;
    logic [31:0] timeout_cfg;
    logic [63:0] cycle_cnt;
    logic [63:0] issued_cnt;
    logic [63:0] rcvd_cnt;
    logic        timeout_flag;
    logic        error_flag;

    // CTRL decode: start together with stop counts as stop only.
    logic ctrl_wr, do_start, do_stop, do_clear, cfg_open;
    assign ctrl_wr  = csr_wr_en[0];
    assign do_start = ctrl_wr & csr_wr_data[0] & ~csr_wr_data[1];
    assign do_stop  = ctrl_wr & csr_wr_data[1];
    assign do_clear = ctrl_wr & csr_wr_data[2];
    assign cfg_open = (state == IDLE) || (state == DONE);

    logic [63:0] issued_inc, cycle_inc, rcvd_inc, issued_next, rcvd_next;
    logic        issue_ok, rsp_ok, limit_hit, timeout_hit;
    assign issued_inc  = issued_cnt + 64'd1;
    assign cycle_inc   = cycle_cnt + 64'd1;
    assign rcvd_inc    = rcvd_cnt + 64'd1;
    assign issue_ok    = (state == RUN) && engine_req_issued;
    assign rsp_ok      = (state != IDLE) && engine_rsp_rcvd;
    assign issued_next = issue_ok ? issued_inc : issued_cnt;
    assign rcvd_next   = rsp_ok ? rcvd_inc : rcvd_cnt;
    // Limit and timeout fire on the edge the counter reaches the programmed value.
    assign limit_hit   = issue_ok && (iter_limit != 32'd0) && (issued_inc == {32'd0, iter_limit});
    assign timeout_hit = (timeout_cfg != 32'd0) && (cycle_inc[31:0] == timeout_cfg);

    assign test_base_addr = base_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            base_addr    <= '0;
            iter_limit   <= '0;
            timeout_cfg  <= '0;
            cycle_cnt    <= '0;
            issued_cnt   <= '0;
            rcvd_cnt     <= '0;
            timeout_flag <= 1'b0;
            error_flag   <= 1'b0;
            test_start   <= 1'b0;
            test_enable  <= 1'b0;
            test_done    <= 1'b0;
        end else begin
            test_start <= 1'b0;

            if (cfg_open) begin
                if (csr_wr_en[1]) base_addr   <= csr_wr_data;
                if (csr_wr_en[2]) iter_limit  <= csr_wr_data[31:0];
                if (csr_wr_en[3]) timeout_cfg <= csr_wr_data[31:0];
            end

            // Overrun responses still count; the sticky flag records the overrun.
            if (rsp_ok) begin
                rcvd_cnt <= rcvd_inc;
                if (rcvd_cnt >= issued_next) error_flag <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (do_start) begin
                        // Later assignments here override the response update above.
                        state        <= RUN;
                        test_start   <= 1'b1;
                        test_enable  <= 1'b1;
                        test_done    <= 1'b0;
                        cycle_cnt    <= '0;
                        issued_cnt   <= '0;
                        rcvd_cnt     <= '0;
                        timeout_flag <= 1'b0;
                        error_flag   <= 1'b0;
                    end else if ((state == DONE) && do_clear) begin
                        state     <= IDLE;
                        test_done <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_cnt  <= cycle_inc;
                    issued_cnt <= issued_next;
                    if (do_stop || timeout_hit || limit_hit) begin
                        state       <= DRAIN;
                        test_enable <= 1'b0;
                    end
                    if (timeout_hit) timeout_flag <= 1'b1;
                end
                DRAIN: begin
                    cycle_cnt <= cycle_inc;
                    if (rcvd_next == issued_cnt) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read slots are a registered snapshot of the previous cycle's state.
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_rd_data <= '0;
        end else begin
            csr_rd_data            <= '0;
            csr_rd_data[63:0]      <= {59'd0, error_flag, timeout_flag, (state == DONE), state};
            csr_rd_data[127:64]    <= cycle_cnt;
            csr_rd_data[191:128]   <= issued_cnt;
            csr_rd_data[255:192]   <= rcvd_cnt;
            csr_rd_data[319:256]   <= issued_cnt - rcvd_cnt;
        end
    end

endmodule
